ifarb: RTL and testbench

System-interface arbiter sharing the single memory/IO interface among up to NREQ requesters (CPU interface control, channels, DMA). Takes per-requester request lines (zg), issues a one-hot registered grant (zw), routes the interface's ok/en responses back to the granted requester, and releases the interface when the owner drops its request. A grant watchdog reclaims the interface from a requester that never receives an answer and never lets go.

---
 rtl/ifarb_pkg.sv | 15 +
 rtl/ifarb_if.sv | 32 +++
 rtl/ifarb_pick.sv | 39 +++
 rtl/ifarb.sv | 161 ++++++++++++++++
 tb/tb_ifarb.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifarb_pkg.sv
// Shared definitions for the system-interface arbiter: FSM state encoding
// and default sizing constants used by the interface and the top level.
package ifarb_pkg;

   typedef enum logic [1:0] {
      IFARB_IDLE  = 2'd0,
      IFARB_GRANT = 2'd1,
      IFARB_HOLD  = 2'd2,
      IFARB_TURN  = 2'd3
   } ifarb_state_e;

   localparam int IFARB_NREQ_DEFAULT          = 4;
   localparam int IFARB_GRANT_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ifarb_if.sv
// Bundle of the arbiter's request/grant/response signals.
// master: requester and memory side (drives zg, rok, ren).
// slave:  the arbiter itself (drives grants, routed answers and status).
interface ifarb_if
   import ifarb_pkg::*;
#(
   parameter int NREQ = IFARB_NREQ_DEFAULT
) ();

   localparam int OWNER_W = $clog2(NREQ);

   logic [NREQ-1:0]    zg;
   logic               rok;
   logic               ren;
   logic [NREQ-1:0]    zw;
   logic [NREQ-1:0]    ok;
   logic [NREQ-1:0]    en;
   logic               busy;
   logic [OWNER_W-1:0] owner;
   logic               tmo;

   modport master (
      output zg, rok, ren,
      input  zw, ok, en, busy, owner, tmo
   );

   modport slave (
      input  zg, rok, ren,
      output zw, ok, en, busy, owner, tmo
   );

endinterface

// File: rtl/ifarb_pick.sv
// Combinational priority picker: finds the first set request at or after
// the start index, wrapping around. With start tied to zero this is plain
// fixed priority with index 0 highest.
module ifarb_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] start,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    valid
);

   localparam int OWNER_W = $clog2(NREQ);

   logic [NREQ-1:0]  req_rot;
   logic [OWNER_W:0] offset;
   logic [OWNER_W:0] sum;

   // Rotate requests so the start index sits at bit 0, take the lowest set
   // bit, then add the start back (mod NREQ) to recover the real index.
   always_comb begin
      req_rot = NREQ'({req, req} >> start);
      offset  = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            offset = (OWNER_W + 1)'(j);
         end
      end
      sum = offset + {1'b0, start};
      if (sum >= (OWNER_W + 1)'(NREQ)) begin
         sum = sum - (OWNER_W + 1)'(NREQ);
      end
      valid = |req;
      idx   = sum[OWNER_W-1:0];
      grant = valid ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/ifarb.sv
// System-interface arbiter: shares one memory/IO interface among NREQ
// requesters with a registered one-hot grant, routes ok/en answers back to
// the owner, inserts a one-cycle turnaround on release, and reclaims the
// interface through a grant watchdog when no answer ever arrives.
// Optional feature: define IFARB_ROUND_ROBIN_EN for rotating priority;
// otherwise fixed priority with requester 0 highest.
module ifarb
   import ifarb_pkg::*;
#(
   parameter int NREQ          = IFARB_NREQ_DEFAULT,
   parameter int GRANT_TIMEOUT = IFARB_GRANT_TIMEOUT_DEFAULT
) (
   input  logic   clk_sys,
   input  logic   clo,
   ifarb_if.slave bus
);

   localparam int OWNER_W = $clog2(NREQ);
   localparam int WDOG_W  = $clog2(GRANT_TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(GRANT_TIMEOUT - 1);

   ifarb_state_e       state_q, state_d;
   logic [NREQ-1:0]    zw_q, zw_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic               tmo_q, tmo_d;
   logic [NREQ-1:0]    mask_q, mask_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;

   logic [NREQ-1:0]    eligible;
   logic [OWNER_W-1:0] pick_start;
   logic [NREQ-1:0]    pick_grant;
   logic [OWNER_W-1:0] pick_idx;
   logic               pick_valid;
   logic               resp;
   logic               owner_req;

   assign resp      = bus.rok | bus.ren;
   assign owner_req = bus.zg[owner_q];
   assign eligible  = bus.zg & ~mask_q;

`ifdef IFARB_ROUND_ROBIN_EN
   logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [OWNER_W:0]   ptr_sum;

   assign pick_start = rr_ptr_q;

   // Rotate priority past each new winner so the search starts just after it.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      ptr_sum  = {1'b0, pick_idx} + (OWNER_W + 1)'(1);
      if (state_q == IFARB_IDLE && pick_valid) begin
         if (ptr_sum == (OWNER_W + 1)'(NREQ)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = ptr_sum[OWNER_W-1:0];
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_sys or posedge clo) begin
      if (clo) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   assign pick_start = '0;
`endif

   ifarb_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req   (eligible),
      .start (pick_start),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Next-state logic: arbitration in IDLE, ownership with watchdog in
   // GRANT, atomic hold while an answer is on the bus, one turnaround cycle.
   always_comb begin
      state_d = state_q;
      zw_d    = zw_q;
      owner_d = owner_q;
      tmo_d   = 1'b0;
      wdog_d  = '0;
      mask_d  = mask_q & bus.zg;
      case (state_q)
         IFARB_IDLE: begin
            if (pick_valid) begin
               state_d = IFARB_GRANT;
               zw_d    = pick_grant;
               owner_d = pick_idx;
            end
         end
         IFARB_GRANT: begin
            if (!owner_req) begin
               state_d = IFARB_TURN;
               zw_d    = '0;
            end else if (resp) begin
               state_d = IFARB_HOLD;
            end else if (wdog_q == WDOG_LAST) begin
               state_d         = IFARB_TURN;
               zw_d            = '0;
               tmo_d           = 1'b1;
               mask_d[owner_q] = 1'b1;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         IFARB_HOLD: begin
            // HOLD is only occupied while an answer is asserted, so a low
            // answer here is the falling edge that re-arms the watchdog.
            if (!owner_req) begin
               state_d = IFARB_TURN;
               zw_d    = '0;
            end else if (!resp) begin
               state_d = IFARB_GRANT;
            end
         end
         IFARB_TURN: begin
            state_d = IFARB_IDLE;
            zw_d    = '0;
         end
         default: begin
            state_d = IFARB_IDLE;
            zw_d    = '0;
         end
      endcase
   end

   // Arbiter state registers; reset drops any grant immediately.
   always_ff @(posedge clk_sys or posedge clo) begin
      if (clo) begin
         state_q <= IFARB_IDLE;
         zw_q    <= '0;
         owner_q <= '0;
         tmo_q   <= 1'b0;
         mask_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         zw_q    <= zw_d;
         owner_q <= owner_d;
         tmo_q   <= tmo_d;
         mask_q  <= mask_d;
         wdog_q  <= wdog_d;
      end
   end

   assign bus.zw    = zw_q;
   assign bus.ok    = bus.rok ? zw_q : '0;
   assign bus.en    = bus.ren ? zw_q : '0;
   assign bus.busy  = (state_q != IFARB_IDLE);
   assign bus.owner = owner_q;
   assign bus.tmo   = tmo_q;

endmodule

// File: tb/tb_ifarb.sv
// Testbench for ifarb: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_ifarb;

   localparam int N = 4;
   localparam int T = 16;

   logic clk = 1'b0;
   logic clo = 1'b0;

   ifarb_if #(.NREQ(N)) bus ();

   ifarb #(
      .NREQ          (N),
      .GRANT_TIMEOUT (T)
   ) dut (
      .clk_sys (clk),
      .clo     (clo),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // Model: phase 0 = free, 1 = owned (grant visible), 2 = turnaround.
   int         m_phase;
   int         m_owner;
   int         m_age;
   bit         m_answered;
   bit         m_tmo;
   bit [N-1:0] m_mask;
   int         m_ptr;
   logic [N-1:0] m_z;
   logic [N-1:0] m_elig;
   bit           m_r;
   int           m_w;
   logic [N-1:0] exp_zw;
   logic [N-1:0] zgv;
   int           rr_order [5];

   function automatic int pickModel(input logic [N-1:0] elig, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (elig[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] zg, input logic rok, input logic ren);
      bus.zg  = zg;
      bus.rok = rok;
      bus.ren = ren;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus('0, 1'b0, 1'b0);
      clo = 1'b1;
      tick();
      tick();
      clo = 1'b0;
   endtask

   // Behavioural model stepped on each clock edge or asynchronous reset.
   initial begin
      m_phase = 0; m_owner = 0; m_age = 0; m_answered = 0;
      m_tmo = 0; m_mask = '0; m_ptr = 0;
      forever begin
         @(posedge clk or posedge clo);
         if (clo) begin
            m_phase = 0; m_owner = 0; m_age = 0; m_answered = 0;
            m_tmo = 0; m_mask = '0; m_ptr = 0;
         end else begin
            m_z    = bus.zg;
            m_r    = bus.rok | bus.ren;
            m_elig = m_z & ~m_mask;
            m_tmo  = 0;
            m_mask = m_mask & m_z;
            case (m_phase)
               0: begin
                  m_w = pickModel(m_elig, m_ptr);
                  if (m_w >= 0) begin
                     m_owner    = m_w;
                     m_phase    = 1;
                     m_age      = 0;
                     m_answered = 0;
`ifdef IFARB_ROUND_ROBIN_EN
                     m_ptr = (m_w + 1) % N;
`endif
                  end
               end
               1: begin
                  if (!m_z[m_owner]) begin
                     m_phase = 2;
                  end else if (m_answered) begin
                     if (!m_r) begin
                        m_answered = 0;
                        m_age      = 0;
                     end
                  end else if (m_r) begin
                     m_answered = 1;
                  end else if (m_age == T - 1) begin
                     m_phase         = 2;
                     m_tmo           = 1;
                     m_mask[m_owner] = 1'b1;
                  end else begin
                     m_age++;
                  end
               end
               default: m_phase = 0;
            endcase
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            exp_zw = (m_phase == 1) ? (N'(1) << m_owner) : '0;
            checkOutput("model_zw", bus.zw, exp_zw);
            checkOutput("model_ok", bus.ok, bus.rok ? exp_zw : '0);
            checkOutput("model_en", bus.en, bus.ren ? exp_zw : '0);
            checkOutput("model_busy", bus.busy, m_phase != 0);
            checkOutput("model_owner", bus.owner, m_owner);
            checkOutput("model_tmo", bus.tmo, m_tmo);
         end
      end
   end

   initial begin
`ifdef IFARB_ROUND_ROBIN_EN
      rr_order = '{0, 1, 2, 3, 0};
`else
      rr_order = '{0, 0, 0, 0, 0};
`endif
      applyStimulus('0, 1'b0, 1'b0);
      #2 clo = 1'b1;
      cmp_en = 1'b1;
      tick();
      checkOutput("reset_zw", bus.zw, 4'b0000);
      checkOutput("reset_busy", bus.busy, 1'b0);
      checkOutput("reset_owner", bus.owner, 0);
      checkOutput("reset_tmo", bus.tmo, 1'b0);
      tick();
      clo = 1'b0;

      // Single request with answer and release.
      doReset();
      applyStimulus(4'b0010, 1'b0, 1'b0);
      tick();
      checkOutput("single_grant", bus.zw, 4'b0010);
      checkOutput("single_owner", bus.owner, 1);
      tick();
      applyStimulus(4'b0010, 1'b1, 1'b0);
      #1 checkOutput("single_ok", bus.ok, 4'b0010);
      tick();
      applyStimulus(4'b0010, 1'b0, 1'b0);
      tick();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      tick();
      checkOutput("single_turn_zw", bus.zw, 4'b0000);
      checkOutput("single_turn_busy", bus.busy, 1'b1);
      tick();
      checkOutput("single_idle_busy", bus.busy, 1'b0);

      // Contention 1011: 0, then 1, then 3.
      doReset();
      applyStimulus(4'b1011, 1'b0, 1'b0);
      tick();
      checkOutput("cont_first", bus.zw, 4'b0001);
      applyStimulus(4'b1010, 1'b0, 1'b0);
      tick();
      checkOutput("cont_turn", bus.zw, 4'b0000);
      tick();
      tick();
      checkOutput("cont_second", bus.zw, 4'b0010);
      applyStimulus(4'b1000, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("cont_third", bus.zw, 4'b1000);

      // All requesting, each owner drops and re-raises after its answer.
      doReset();
      zgv = 4'b1111;
      applyStimulus(zgv, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("order_%0d", k), bus.zw, N'(1) << rr_order[k]);
         applyStimulus(zgv, 1'b1, 1'b0);
         tick();
         zgv[rr_order[k]] = 1'b0;
         applyStimulus(zgv, 1'b0, 1'b0);
         tick();
         zgv = 4'b1111;
         applyStimulus(zgv, 1'b0, 1'b0);
         tick();
      end

      // Watchdog release, masking, and re-grant after a drop.
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      tick();
      checkOutput("wd_grant", bus.zw, 4'b0100);
      for (int k = 0; k < T - 1; k++) tick();
      checkOutput("wd_before_zw", bus.zw, 4'b0100);
      checkOutput("wd_before_tmo", bus.tmo, 1'b0);
      tick();
      checkOutput("wd_release_zw", bus.zw, 4'b0000);
      checkOutput("wd_release_tmo", bus.tmo, 1'b1);
      tick();
      checkOutput("wd_tmo_pulse", bus.tmo, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      checkOutput("wd_masked_zw", bus.zw, 4'b0000);
      checkOutput("wd_masked_busy", bus.busy, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      tick();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      tick();
      checkOutput("wd_regrant", bus.zw, 4'b0100);

      // Atomic hold: two accesses by owner 1 while 3 waits.
      doReset();
      applyStimulus(4'b0010, 1'b0, 1'b0);
      tick();
      checkOutput("atom_grant", bus.zw, 4'b0010);
      applyStimulus(4'b1010, 1'b1, 1'b0);
      #1 checkOutput("atom_ok", bus.ok, 4'b0010);
      tick();
      applyStimulus(4'b1010, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(4'b1010, 1'b0, 1'b1);
      #1 checkOutput("atom_en", bus.en, 4'b0010);
      checkOutput("atom_still_owner", bus.zw, 4'b0010);
      tick();
      applyStimulus(4'b1010, 1'b0, 1'b0);
      checkOutput("atom_hold_zw", bus.zw, 4'b0010);
      tick();
      applyStimulus(4'b1000, 1'b0, 1'b0);
      tick();
      checkOutput("atom_turn", bus.zw, 4'b0000);
      tick();
      tick();
      checkOutput("atom_next", bus.zw, 4'b1000);

      // Reset in the middle of a grant.
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      tick();
      checkOutput("rst_grant", bus.zw, 4'b0100);
      #2 clo = 1'b1;
      #1;
      checkOutput("rst_async_zw", bus.zw, 4'b0000);
      checkOutput("rst_async_busy", bus.busy, 1'b0);
      checkOutput("rst_async_tmo", bus.tmo, 1'b0);
      tick();
      clo = 1'b0;
      applyStimulus(4'b0000, 1'b0, 1'b0);
      tick();
      checkOutput("rst_after_tmo", bus.tmo, 1'b0);

      // Randomized traffic with occasional reset pulses.
      doReset();
      zgv = '0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 19) == 0) zgv[i] = ~zgv[i];
         end
         if ($urandom_range(0, 29) == 0) begin
            applyStimulus(zgv, 1'b1, 1'b0);
         end else if ($urandom_range(0, 39) == 0) begin
            applyStimulus(zgv, 1'b0, 1'b1);
         end else if ($urandom_range(0, 199) == 0) begin
            applyStimulus(zgv, 1'b1, 1'b1);
         end else begin
            applyStimulus(zgv, 1'b0, 1'b0);
         end
         if ($urandom_range(0, 499) == 0) begin
            clo = 1'b1;
            #3 clo = 1'b0;
         end
         tick();
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
